perceptron_trainer: RTL
=======================

// Module: perceptron_trainer
// PURPOSE
//  Parametrised single-layer perceptron with an on-chip training FSM: N_IN binary inputs,
//  signed saturating W_WIDTH-bit weights plus bias, and a DEPTH-entry sample buffer.
//  After START it trains one sample per cycle, epoch after epoch, until an error-free
//  epoch or MAX_EPOCH. A registered inference port runs in any state.
//  Successor to the fixed 2-input, 4-bit, externally-stepped perceptron datapath.
// PARAMETERS
//  N_IN      2          number of binary inputs (>=1)
//  W_WIDTH   4          weight/bias width, signed two's complement (>=2)
//  DEPTH     4          sample buffer entries (>=1)
//  MAX_EPOCH 15         epoch limit; EPOCH width EW=$clog2(MAX_EPOCH+1)
//  INI_W     {4'd2,4'd1} packed initial weights, w[k] = INI_W[k*W_WIDTH +: W_WIDTH]
//  INI_B     0          initial bias
// PORTS
//  CLK        in   1                 clock, all state on rising edge
//  RST        in   1                 synchronous, active-high reset
//  LOAD_VALID in   1                 sample write request
//  LOAD_READY out  1                 (state==IDLE) && (NSAMP<DEPTH) && !RST
//  LOAD_X     in   N_IN              sample inputs
//  LOAD_S     in   1                 sample target
//  CLR_BUF    in   1                 IDLE only: NSAMP<=0; weights untouched
//  START      in   1                 begin training (IDLE only)
//  BUSY       out  1                 1 while in TRAIN
//  DONE       out  1                 one-cycle pulse when training ends
//  CONVERGED  out  1                 1 = last run ended on error-free epoch; held until next START
//  EPOCH      out  EW                epochs completed in current/last run
//  W          out  N_IN*W_WIDTH      current weights, packed
//  B          out  W_WIDTH           current bias
//  Z          out  1                 step output of the sample trained last cycle
//  DELTA      out  2                 signed S-Z of that sample: 2'b01=+1, 2'b00=0, 2'b11=-1
//  Q_X        in   N_IN              inference inputs
//  Q_Z        out  1                 step(Q_X, current W/B), registered, 1-cycle latency
// BEHAVIOUR
//  Reset: state IDLE, NSAMP=0, W=INI_W, B=INI_B, EPOCH=0, BUSY=DONE=CONVERGED=0,
//   Z=0, DELTA=0, Q_Z=0. RST has priority over every other input in the same cycle,
//   including mid-training (run aborted, buffer cleared, no DONE).
//  MAC: mac = B + sum(x[k] ? w[k] : 0), signed, width W_WIDTH+$clog2(N_IN+1), no overflow.
//   z = (mac > 0). Zero maps to 0.
//  Load: a handshake (LOAD_VALID&&LOAD_READY) writes entry NSAMP and increments NSAMP.
//   CLR_BUF takes priority over a same-cycle load. START takes priority over a
//   same-cycle load (the load is dropped because LOAD_READY falls next cycle; it is
//   not written this cycle either).
//  FSM IDLE -> TRAIN on START && NSAMP>0; clears EPOCH, CONVERGED and the error
//   count. START with NSAMP==0, or START outside IDLE, is ignored.
//  TRAIN: one sample per cycle, index i = 0..NSAMP-1, wrapping back to 0 each epoch.
//   delta = S - z. Updates: w[k] += x[k]*delta and B += delta. Each result saturates
//   to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1]. Z and DELTA register this sample's values.
//   Any delta!=0 sets the epoch error flag.
//  End of epoch (i==NSAMP-1): EPOCH+=1.
//   - No error in this epoch (this sample included): -> IDLE, CONVERGED=1.
//   - Else if EPOCH+1==MAX_EPOCH: -> IDLE, CONVERGED=0.
//   - Else: clear the error flag and continue at i=0.
//   DONE pulses in the first IDLE cycle after a run.
//  Timing: START sampled at edge t. Sample i of epoch e trains in cycle t+1+e*NSAMP+i.
//   DONE is high in the following cycle.
//  Q_Z uses W/B as registered at the same edge, i.e. pre-update weights during TRAIN.
// TESTING
//  1. Defaults. Load AND truth table (00->0, 01->0, 10->0, 11->1), START at t.
//     -> epoch1 one error at sample 01 (DELTA=-1), DONE at t+9,
//        EPOCH=2, CONVERGED=1, W={1,1}, B=-1 (4'hF).
//  2. INI_W={7,-8}, INI_B=7. Load single sample 11->0.
//     -> after first TRAIN cycle w0=-8 (saturated), w1=6, B=6, DELTA=2'b11.
//     -> run continues until converged; no weight ever leaves [-8,7].
//  3. Load XOR table, MAX_EPOCH=15.
//     -> DONE at t+61, CONVERGED=0, EPOCH=15, BUSY low from t+61.
//  4. Load 4 samples with DEPTH=4; keep LOAD_VALID high.
//     -> LOAD_READY=0 and NSAMP stays 4. CLR_BUF -> LOAD_READY=1.
//     START with empty buffer -> BUSY stays 0, no DONE.
//  5. Assert RST in cycle t+3 of test 1.
//     -> next cycle all outputs at reset values, W={2,1}, B=0, no DONE pulse.
//  6. After test 1, drive Q_X=11 then 01.
//     -> Q_Z=1 then 0, each one cycle later.

Source files
------------

// File: rtl/perceptron_trainer.sv
`default_nettype none
// ============================================================================
// Module   : perceptron_trainer
// Purpose  : Single-layer perceptron with sample buffer, on-chip training FSM
//            and a registered inference port.
// Revision : 1.0
// ============================================================================
module perceptron_trainer #(
    parameter int                        N_IN      = 2,
    parameter int                        W_WIDTH   = 4,
    parameter int                        DEPTH     = 4,
    parameter int                        MAX_EPOCH = 15,
    parameter logic [N_IN*W_WIDTH-1:0]   INI_W     = {4'd2, 4'd1},
    parameter logic [W_WIDTH-1:0]        INI_B     = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              load_valid_i,
    output logic                              load_ready_o,
    input  logic [N_IN-1:0]                   load_x_i,
    input  logic                              load_s_i,
    input  logic                              clr_buf_i,
    input  logic                              start_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              converged_o,
    output logic [$clog2(MAX_EPOCH+1)-1:0]    epoch_o,
    output logic [N_IN*W_WIDTH-1:0]           w_o,
    output logic [W_WIDTH-1:0]                b_o,
    output logic                              z_o,
    output logic [1:0]                        delta_o,
    input  logic [N_IN-1:0]                   q_x_i,
    output logic                              q_z_o
);

    localparam int EW = $clog2(MAX_EPOCH + 1);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MW = W_WIDTH + $clog2(N_IN + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_TRAIN = 1'b1;

    localparam logic signed [W_WIDTH:0] SAT_MAX = {2'b00, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH:0] SAT_MIN = {2'b11, {(W_WIDTH-1){1'b0}}};

    // One guard bit is enough since the increment is only -1, 0 or +1.
    function automatic logic [W_WIDTH-1:0] sat_add(input logic [W_WIDTH-1:0] a,
                                                   input logic [1:0]         d);
        logic signed [W_WIDTH:0] s;
        s = $signed({a[W_WIDTH-1], a}) + $signed({{(W_WIDTH-1){d[1]}}, d});
        if (s > SAT_MAX)      return SAT_MAX[W_WIDTH-1:0];
        else if (s < SAT_MIN) return SAT_MIN[W_WIDTH-1:0];
        else                  return s[W_WIDTH-1:0];
    endfunction

    function automatic logic step(input logic [N_IN-1:0]         x,
                                  input logic [N_IN*W_WIDTH-1:0] w,
                                  input logic [W_WIDTH-1:0]      b);
        logic signed [MW-1:0] acc;
        acc = MW'($signed(b));
        for (int k = 0; k < N_IN; k++) begin
            if (x[k]) acc = acc + MW'($signed(w[k*W_WIDTH +: W_WIDTH]));
        end
        return !acc[MW-1] && (acc != '0);
    endfunction

    logic [0:0]              state_q, state_d;
    logic [NW-1:0]           nsamp_q, nsamp_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic                    err_q, err_d;
    logic [EW-1:0]           epoch_q, epoch_d;
    logic [N_IN*W_WIDTH-1:0] w_q, w_d;
    logic [W_WIDTH-1:0]      b_q, b_d;
    logic                    done_q, done_d;
    logic                    conv_q, conv_d;
    logic                    z_q, z_d;
    logic [1:0]              delta_q, delta_d;
    logic                    qz_q, qz_d;

    logic [N_IN-1:0]         buf_x_q [DEPTH];
    logic                    buf_s_q [DEPTH];

    logic                    w_load_ready;
    logic                    w_start_go;
    logic                    w_load_fire;
    logic [N_IN-1:0]         w_cur_x;
    logic                    w_cur_s;
    logic                    w_z;
    logic [1:0]              w_delta;
    logic                    w_last;
    logic                    w_err;
    logic [EW-1:0]           w_epoch_inc;

    assign w_load_ready = (state_q == ST_IDLE) && (nsamp_q < NW'(DEPTH)) && !rst_i;
    assign w_start_go   = (state_q == ST_IDLE) && start_i && (nsamp_q != '0) && !clr_buf_i;
    assign w_load_fire  = load_valid_i && w_load_ready && !clr_buf_i && !w_start_go;

    assign w_cur_x     = buf_x_q[idx_q];
    assign w_cur_s     = buf_s_q[idx_q];
    assign w_z         = step(w_cur_x, w_q, b_q);
    assign w_delta     = (w_cur_s == w_z) ? 2'b00 : (w_cur_s ? 2'b01 : 2'b11);
    assign w_last      = (NW'(idx_q) == nsamp_q - NW'(1));
    assign w_err       = err_q | (w_delta != 2'b00);
    assign w_epoch_inc = epoch_q + EW'(1);

    always_comb begin
        state_d = state_q;
        nsamp_d = nsamp_q;
        idx_d   = idx_q;
        err_d   = err_q;
        epoch_d = epoch_q;
        w_d     = w_q;
        b_d     = b_q;
        done_d  = 1'b0;
        conv_d  = conv_q;
        z_d     = z_q;
        delta_d = delta_q;
        qz_d    = step(q_x_i, w_q, b_q);
        case (state_q)
            ST_IDLE: begin
                if (clr_buf_i) begin
                    nsamp_d = '0;
                end else if (w_start_go) begin
                    state_d = ST_TRAIN;
                    idx_d   = '0;
                    epoch_d = '0;
                    conv_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (w_load_fire) begin
                    nsamp_d = nsamp_q + NW'(1);
                end
            end
            ST_TRAIN: begin
                z_d     = w_z;
                delta_d = w_delta;
                for (int k = 0; k < N_IN; k++) begin
                    if (w_cur_x[k]) w_d[k*W_WIDTH +: W_WIDTH] = sat_add(w_q[k*W_WIDTH +: W_WIDTH], w_delta);
                end
                b_d = sat_add(b_q, w_delta);
                if (w_last) begin
                    epoch_d = w_epoch_inc;
                    // The error flag includes the sample being trained right now.
                    if (!w_err) begin
                        state_d = ST_IDLE;
                        conv_d  = 1'b1;
                        done_d  = 1'b1;
                    end else if (w_epoch_inc == EW'(MAX_EPOCH)) begin
                        state_d = ST_IDLE;
                        conv_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        idx_d = '0;
                    end
                end else begin
                    idx_d = idx_q + AW'(1);
                    err_d = w_err;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            nsamp_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            epoch_q <= '0;
            w_q     <= INI_W;
            b_q     <= INI_B;
            done_q  <= 1'b0;
            conv_q  <= 1'b0;
            z_q     <= 1'b0;
            delta_q <= 2'b00;
            qz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            nsamp_q <= nsamp_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            epoch_q <= epoch_d;
            w_q     <= w_d;
            b_q     <= b_d;
            done_q  <= done_d;
            conv_q  <= conv_d;
            z_q     <= z_d;
            delta_q <= delta_d;
            qz_q    <= qz_d;
        end
    end

    // Buffer storage needs no reset; validity is tracked by nsamp_q.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_load_fire) begin
            buf_x_q[nsamp_q[AW-1:0]] <= load_x_i;
            buf_s_q[nsamp_q[AW-1:0]] <= load_s_i;
        end
    end

    assign load_ready_o = w_load_ready;
    assign busy_o       = (state_q == ST_TRAIN);
    assign done_o       = done_q;
    assign converged_o  = conv_q;
    assign epoch_o      = epoch_q;
    assign w_o          = w_q;
    assign b_o          = b_q;
    assign z_o          = z_q;
    assign delta_o      = delta_q;
    assign q_z_o        = qz_q;

endmodule
`default_nettype wire
